// File: rtl/adc_driver.sv
// Serial reader for a 12-bit, 8-channel SPI-style ADC (ADC128S022 class).
// One start request runs a 16-sclk frame and publishes the result with a one-cycle done pulse.
module adc_driver #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [2:0]  ch,
    output logic        cs_n,
    output logic        sclk,
    output logic        din,
    input  logic        dout,
    output logic [11:0] data,
    output logic [2:0]  data_ch,
    output logic        cvt_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT  = 5'd15;
    localparam logic [4:0] BIT_LIMIT = 5'd16;

    state_t      state_q, state_d;
    logic [7:0]  half_cnt_q, half_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] addr_shift_q, addr_shift_d;
    logic [11:0] rx_shift_q, rx_shift_d;
    logic [2:0]  ch_r_q, ch_r_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        din_q, din_d;
    logic [11:0] data_q, data_d;
    logic [2:0]  data_ch_q, data_ch_d;
    logic        cvt_done_q, cvt_done_d;
    logic        busy_q, busy_d;

    logic        half_end;
    logic [7:0]  half_next;

    assign half_end  = (half_cnt_q == HALF_LAST);
    assign half_next = half_end ? 8'd0 : half_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        half_cnt_d   = half_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        addr_shift_d = addr_shift_q;
        rx_shift_d   = rx_shift_q;
        ch_r_d       = ch_r_q;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        din_d        = din_q;
        data_d       = data_q;
        data_ch_d    = data_ch_q;
        cvt_done_d   = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                half_cnt_d = 8'd0;
                bit_cnt_d  = 5'd0;
                if (en && !busy_q) begin
                    ch_r_d       = ch;
                    cs_n_d       = 1'b0;
                    busy_d       = 1'b1;
                    addr_shift_d = {2'b00, ch, 11'b0};
                    state_d      = SHIFT;
                end
            end

            SHIFT: begin
                half_cnt_d = half_next;
                if (half_end) begin
                    if (sclk_q) begin
                        sclk_d       = 1'b0;
                        din_d        = addr_shift_q[15];
                        addr_shift_d = {addr_shift_q[14:0], 1'b0};
                    end else begin
                        // Only the last 12 bits survive; the 4 leading bits fall off the top.
                        sclk_d     = 1'b1;
                        rx_shift_d = {rx_shift_q[10:0], dout};
                        if (bit_cnt_q != BIT_LIMIT) begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            DONE: begin
                half_cnt_d = half_next;
                if (half_end) begin
                    cs_n_d     = 1'b1;
                    data_d     = rx_shift_q;
                    data_ch_d  = ch_r_q;
                    cvt_done_d = 1'b1;
                    state_d    = GAP;
                end
            end

            GAP: begin
                half_cnt_d = half_next;
                if (half_end) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d      = IDLE;
                half_cnt_d   = 8'd0;
                bit_cnt_d    = 5'd0;
                addr_shift_d = 16'd0;
                rx_shift_d   = 12'd0;
                ch_r_d       = 3'd0;
                cs_n_d       = 1'b1;
                sclk_d       = 1'b1;
                din_d        = 1'b0;
                data_d       = 12'd0;
                data_ch_d    = 3'd0;
                cvt_done_d   = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            half_cnt_q   <= 8'd0;
            bit_cnt_q    <= 5'd0;
            addr_shift_q <= 16'd0;
            rx_shift_q   <= 12'd0;
            ch_r_q       <= 3'd0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b1;
            din_q        <= 1'b0;
            data_q       <= 12'd0;
            data_ch_q    <= 3'd0;
            cvt_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_shift_q <= addr_shift_d;
            rx_shift_q   <= rx_shift_d;
            ch_r_q       <= ch_r_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            din_q        <= din_d;
            data_q       <= data_d;
            data_ch_q    <= data_ch_d;
            cvt_done_q   <= cvt_done_d;
            busy_q       <= busy_d;
        end
    end

    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign din      = din_q;
    assign data     = data_q;
    assign data_ch  = data_ch_q;
    assign cvt_done = cvt_done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_adc_driver.sv
// Bench for adc_driver: lane 0 built with CLK_DIV=2, lane 1 with CLK_DIV=1, each with its own ADC model.
// Expected frames go into a scoreboard at acceptance; a negedge monitor pops and compares them.
module tb_adc_driver;

    localparam int LANES = 2;
    localparam int DIV0  = 2;
    localparam int DIV1  = 1;

    typedef struct {
        int         lane;
        logic [11:0] value;
        logic [2:0]  chan;
        int         doneCycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN    [LANES];
    logic        en      [LANES];
    logic [2:0]  ch      [LANES];
    logic        dout    [LANES];
    logic        csN     [LANES];
    logic        sclk    [LANES];
    logic        din     [LANES];
    logic [11:0] data    [LANES];
    logic [2:0]  dataCh  [LANES];
    logic        cvtDone [LANES];
    logic        busy    [LANES];

    exp_t        sb[$];
    int          cyc = 0;
    int          e0        [LANES] = '{-1, -1};
    logic [11:0] frameVal  [LANES];
    logic [2:0]  frameCh   [LANES];
    logic [11:0] lastData  [LANES];
    logic [2:0]  lastCh    [LANES];
    logic [11:0] planVal   [LANES][16];
    int          planWr    [LANES] = '{0, 0};
    int          planRd    [LANES] = '{0, 0};
    int          bitIdx    [LANES] = '{0, 0};
    logic        prevSclk  [LANES] = '{1'b1, 1'b1};

    int          tests = 0;
    int          fails = 0;
    logic        doFinal = 1'b0;
    logic        finalDone = 1'b0;

    always #5 clk = ~clk;

    adc_driver #(.CLK_DIV(DIV0)) dut0 (
        .clk(clk), .rst_n(rstN[0]), .en(en[0]), .ch(ch[0]),
        .cs_n(csN[0]), .sclk(sclk[0]), .din(din[0]), .dout(dout[0]),
        .data(data[0]), .data_ch(dataCh[0]), .cvt_done(cvtDone[0]), .busy(busy[0])
    );

    adc_driver #(.CLK_DIV(DIV1)) dut1 (
        .clk(clk), .rst_n(rstN[1]), .en(en[1]), .ch(ch[1]),
        .cs_n(csN[1]), .sclk(sclk[1]), .din(din[1]), .dout(dout[1]),
        .data(data[1]), .data_ch(dataCh[1]), .cvt_done(cvtDone[1]), .busy(busy[1])
    );

    function automatic int divOf(input int lane);
        return (lane == 0) ? DIV0 : DIV1;
    endfunction

    // Address pattern on din: 0, 0, ch[2], ch[1], ch[0], then zeros.
    function automatic logic addrBit(input logic [2:0] chan, input int k);
        case (k)
            2:       return chan[2];
            3:       return chan[1];
            4:       return chan[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic void checkOutput(input string name, input int lane,
                                        input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("[TB] FAIL %s lane%0d cycle %0d: got %0h, expected %0h",
                         name, lane, cyc, act, exp);
        end
    endfunction

    // Reference model: frame acceptance and result publication derived from the frame timeline.
    always @(posedge clk) begin
        cyc++;
        for (int l = 0; l < LANES; l++) begin
            int t;
            t = divOf(l);
            if (rstN[l] !== 1'b1) begin
                e0[l]       = -1;
                lastData[l] = 12'd0;
                lastCh[l]   = 3'd0;
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].lane == l) sb.delete(i);
            end else begin
                if (e0[l] >= 0 && cyc == e0[l] + 33 * t) begin
                    lastData[l] = frameVal[l];
                    lastCh[l]   = frameCh[l];
                end
                if (en[l] && (e0[l] < 0 || cyc > e0[l] + 34 * t)) begin
                    e0[l]      = cyc;
                    frameCh[l] = ch[l];
                    if (planRd[l] < planWr[l]) begin
                        frameVal[l] = planVal[l][planRd[l] % 16];
                        planRd[l]++;
                    end else begin
                        frameVal[l] = 12'($urandom_range(0, 4095));
                    end
                    sb.push_back('{lane: l, value: frameVal[l], chan: frameCh[l],
                                   doneCycle: cyc + 33 * t});
                end
            end
        end
    end

    // ADC models: present the next bit of {4'b0, value} after every sclk fall.
    always @(negedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            logic [15:0] bits;
            bits = {4'b0000, frameVal[l]};
            if (csN[l] !== 1'b0) begin
                bitIdx[l] = 0;
            end else if (prevSclk[l] && !sclk[l]) begin
                dout[l] = (bitIdx[l] < 16) ? bits[15 - bitIdx[l]] : 1'b0;
                bitIdx[l]++;
            end
            prevSclk[l] = sclk[l];
        end
    end

    // Monitor: per-cycle pin expectations plus scoreboard pop on every cvt_done.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int l = 0; l < LANES; l++) begin
                int   t, j, m, idx;
                logic expBusy, expCs, expSclk, expDin, expDone;
                t       = divOf(l);
                j       = (e0[l] >= 0) ? cyc - e0[l] : -1;
                expBusy = (j >= 0) && (j < 34 * t);
                expCs   = !((j >= 0) && (j < 33 * t));
                expDone = (j >= 0) && (j == 33 * t);
                expSclk = 1'b1;
                expDin  = 1'b0;
                if (j >= t && j <= 32 * t) begin
                    m       = j / t;
                    expSclk = (m % 2 == 0);
                    expDin  = addrBit(frameCh[l], (m - 1) / 2);
                end
                checkOutput("busy", l, 32'(busy[l]), 32'(expBusy));
                checkOutput("cs_n", l, 32'(csN[l]), 32'(expCs));
                checkOutput("sclk", l, 32'(sclk[l]), 32'(expSclk));
                checkOutput("din", l, 32'(din[l]), 32'(expDin));
                checkOutput("cvt_done", l, 32'(cvtDone[l]), 32'(expDone));
                checkOutput("data", l, 32'(data[l]), 32'(lastData[l]));
                checkOutput("data_ch", l, 32'(dataCh[l]), 32'(lastCh[l]));
                if (cvtDone[l] === 1'b1) begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (idx < 0 && sb[i].lane == l) idx = i;
                    if (idx < 0) begin
                        checkOutput("unexpected done", l, 32'd1, 32'd0);
                    end else begin
                        checkOutput("sb data", l, 32'(data[l]), 32'(sb[idx].value));
                        checkOutput("sb channel", l, 32'(dataCh[l]), 32'(sb[idx].chan));
                        checkOutput("sb done cycle", l, 32'(cyc), 32'(sb[idx].doneCycle));
                        sb.delete(idx);
                    end
                end
            end
            if (doFinal && !finalDone) begin
                checkOutput("pending results", 0, 32'(sb.size()), 32'd0);
                finalDone = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input int lane, input logic enVal, input logic [2:0] chVal);
        @(negedge clk);
        en[lane] = enVal;
        ch[lane] = chVal;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic planValue(input int lane, input logic [11:0] val);
        planVal[lane][planWr[lane] % 16] = val;
        planWr[lane]++;
    endtask

    task automatic pulse(input int lane, input logic [2:0] chVal);
        applyStimulus(lane, 1'b1, chVal);
        applyStimulus(lane, 1'b0, chVal);
    endtask

    initial begin
        for (int l = 0; l < LANES; l++) begin
            rstN[l] = 1'b0;
            en[l]   = 1'b0;
            ch[l]   = 3'd0;
            dout[l] = 1'b0;
        end
        idle(3);
        rstN[0] = 1'b1;
        rstN[1] = 1'b1;
        idle(100);

        // Single conversion with two ignored starts inside the frame.
        planValue(0, 12'hA5C);
        pulse(0, 3'd5);
        idle(8);
        pulse(0, 3'd2);
        idle(28);
        pulse(0, 3'd2);
        idle(60);

        // Back-to-back frames with en held.
        planValue(0, 12'hFFF);
        planValue(0, 12'h000);
        applyStimulus(0, 1'b1, 3'd7);
        idle(100);
        applyStimulus(0, 1'b0, 3'd7);
        idle(80);

        // Reset sampled at E0+30, then a normal conversion.
        pulse(0, 3'd6);
        idle(29);
        rstN[0] = 1'b0;
        @(negedge clk);
        rstN[0] = 1'b1;
        idle(20);
        pulse(0, 3'd1);
        idle(80);

        // Fast build: sclk every clk.
        planValue(1, 12'h123);
        pulse(1, 3'd3);
        idle(50);

        // Randomized traffic: held starts with ch changing, gaps and occasional resets.
        for (int it = 0; it < 24; it++) begin
            int lane, hold;
            lane = $urandom_range(0, 1);
            hold = $urandom_range(1, 90);
            for (int c = 0; c < hold; c++)
                applyStimulus(lane, 1'b1, 3'($urandom_range(0, 7)));
            applyStimulus(lane, 1'b0, 3'd0);
            if ($urandom_range(0, 5) == 0) begin
                idle($urandom_range(0, 40));
                rstN[lane] = 1'b0;
                @(negedge clk);
                rstN[lane] = 1'b1;
            end
            idle($urandom_range(0, 40));
        end

        idle(150);
        @(negedge clk);
        doFinal = 1'b1;
        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_driver.md
Name: adc_driver

Overview:
- Serial reader for a 12-bit, 8-channel SPI-style ADC (ADC128S022-class); it is the read-direction counterpart of the DAC serial driver.
- On a start pulse it runs one 16-clock frame:
  - drives cs_n, sclk and din (channel address) to the ADC;
  - shifts in the ADC's dout;
  - presents the 12-bit result with a one-cycle done pulse.
- Sits between the board ADC pins and sampling/processing logic, on the system clock.

Parameters:
- CLK_DIV, 2, clk cycles per sclk half-period (T); sclk = f_clk/(2*CLK_DIV); legal range 1..255; default gives 12.5 MHz from 50 MHz.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  start request, sampled only when busy=0
- ch  input  3  channel to convert, latched on accepted en
- cs_n  output  1  ADC chip select, active-low
- sclk  output  1  ADC serial clock, idles high
- din  output  1  serial address to ADC, MSB first
- dout  input  1  serial data from ADC, MSB first
- data  output  12  last conversion result, held until next cvt_done
- data_ch  output  3  channel that produced data
- cvt_done  output  1  one-cycle pulse: data/data_ch updated
- busy  output  1  high from accepted en until ready for next en

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - cs_n=1, sclk=1, din=0, busy=0, cvt_done=0;
  - data=0, data_ch=0;
  - FSM=IDLE, counters=0, shift registers=0.
- Reset takes effect at that edge even mid-frame; no partial result is ever published.
- Register all outputs; no combinational path from inputs to outputs.
- FSM states: IDLE, SHIFT, DONE, GAP.
- Timing notation: E0 is the clk edge where en=1 is sampled with busy=0; T=CLK_DIV.
- IDLE:
  - At E0: latch ch into ch_r; cs_n<=0; busy<=1; address shift reg<={2'b00, ch, 11'b0}; go to SHIFT.
  - en while busy=1 is ignored entirely, with no queueing.
- SHIFT, 16 bits, k=0..15:
  - Falling edge at E0+(2k+1)T: sclk<=0 and din<=address bit (15-k).
  - Rising edge at E0+(2k+2)T: sclk<=1 and rx_shift<={rx_shift[14:0], dout}, using the dout value present at that edge.
  - After the rise at E0+32T, go to DONE.
  - Resulting din pattern: 0,0,ch[2],ch[1],ch[0], then 11 zeros.
- DONE, at E0+33T:
  - cs_n<=1; data<=rx_shift[11:0]; data_ch<=ch_r; cvt_done<=1 for exactly one cycle.
  - The first 4 received bits are discarded.
  - sclk stays 1.
- GAP: hold cs_n=1 for T cycles after DONE (minimum CS-high time), then busy<=0 at E0+34T, go to IDLE.
- Next-frame timing:
  - The earliest next E0 is the edge after busy falls.
  - With en held high continuously, frames repeat every 34T+1 cycles.
- Default-parameter timing (T=2): cs_n falls at E0, cvt_done high at E0+66, busy low at E0+68.
- Half-period counter:
  - Width 8 bits; counts 0..T-1; wraps to 0 on each sclk toggle.
  - With T=1, sclk toggles every clk.
- Bit counter: 5 bits, 0..16, no wrap beyond 16.
- Illegal states: go to IDLE with outputs at their reset values.
- data and data_ch are stable outside the cvt_done update edge.
- cvt_done and busy: never both 0 within the first 34T cycles after E0.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 clks, en=0.
  - Required: cs_n=1, sclk=1, din=0, busy=0, cvt_done=0, data=0, data_ch=0.
  - All hold for 100 idle clks.
- Single conversion, CLK_DIV=2: pulse en with ch=5; ADC model drives 4'b0000 then 12'hA5C on sclk falling edges.
  - Required: cs_n low from E0 to E0+66; 16 sclk low pulses, each 2 clks.
  - Required: din bits 0,0,1,0,1 then zeros.
  - Required: cvt_done=1 only at E0+66; data=12'hA5C; data_ch=5; busy low at E0+68.
- Ignored start: pulse en again at E0+10 and E0+40 with ch=2.
  - Required: no frame restart; data_ch=5 for this frame; exactly one cvt_done.
- Back-to-back: hold en=1 with ch=7; model returns 12'hFFF then 12'h000.
  - Required: second cs_n fall at E0+69.
  - Required: results 12'hFFF then 12'h000; data_ch=7 both times.
- Reset mid-frame: assert rst_n=0 for 1 clk at E0+30.
  - Required: next edge shows cs_n=1, sclk=1, busy=0.
  - Required: no cvt_done; data keeps reset value 0; a new en then converts normally.
- CLK_DIV=1 build, model value 12'h123, ch=3.
  - Required: sclk toggles every clk; cvt_done at E0+33; busy low at E0+34; data=12'h123.
